// File: rtl/sample_uart_pkg.sv
// Shared types and constants for the sample UART transmitter.
// Frame layout: sync byte, sample high byte, sample low byte.
package sample_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 3;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with extra-bit pointers.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sample_uart_tx.sv
// Buffers decimated samples and sends each one as a
// 3-byte 8N1 UART frame: A5, sample[15:8], sample[7:0].
module sample_uart_tx
  import sample_uart_pkg::*;
#(
  parameter int SAMPLE_W     = 9,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                clear_ovf,
  output logic                tx_out,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam int            CW       = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(FRAME_BYTES - 1);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;
  logic [23:0]   frame_q;
  logic          tx_q;
  logic          tx_d;
  logic          ovf_q;
  logic [7:0]    drop_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic [15:0]         sample_ext;
  logic [7:0]          cur_byte;
  logic                cnt_last;
  logic                drop;

  assign fifo_pop   = (state_q == IDLE) & ~fifo_empty;
  assign drop       = sample_valid & fifo_full & ~fifo_pop;
  assign sample_ext = 16'(fifo_dout);
  assign cur_byte   = frame_q[23:16];
  assign cnt_last   = (cnt_q == CNT_LAST);

  assign tx_out     = tx_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (sample_valid),
    .pop_i   (fifo_pop),
    .din_i   (sample),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Line level for the current state, registered below
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  // Serializer FSM with baud counter and registered line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_q <= tx_d;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            frame_q <= {SYNC_BYTE, sample_ext};
            byte_q  <= '0;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q <= '0;
            if (byte_q < LAST_BYTE) begin
              byte_q  <= byte_q + 2'd1;
              frame_q <= {frame_q[15:0], 8'h00};
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (clear_ovf)           drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (clear_ovf) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end
  end

endmodule
